// File: rtl/code_lock_pkg.sv
// Shared definitions for the combination-lock controller: state encoding,
// default timing constants and the code digit-slice helper.
package code_lock_pkg;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2,
        PROG     = 2'd3
    } lock_state_t;

    localparam logic [31:0] DEF_UNLOCK_CYC   = 32'd2_000_000_000;
    localparam logic [31:0] DEF_LOCKOUT_CYC  = 32'd4_000_000_000;
    localparam logic [31:0] DEF_ENTRY_TO_CYC = 32'd500_000_000;

    // Returns digit idx (w bits wide, zero-extended to 8) of a packed code
    // whose digit 0 sits in the least significant bits.
    function automatic logic [7:0] digit_slice(input logic [63:0] code,
                                               input int idx,
                                               input int w);
        logic [63:0] shifted;
        shifted = code >> (idx * w);
        return shifted[7:0] & 8'((1 << w) - 1);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Shared state/entry timer: free-running 32-bit up-counter that restarts
// from zero on clear and flags the cycle in which it reaches limit-1.
module cycle_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] count;

    // Count up every cycle; a clear makes the next cycle read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign expired = (count == (limit - 32'd1));

endmodule

// File: rtl/code_lock_ctrl.sv
// Combination-lock controller: accepts one key per strobe, only judges the
// code after the last digit, counts failures into a timed lockout, discards
// stale partial entries and auto-relocks after a while.
// Build option: define CODE_PROG_EN to allow reprogramming the code while
// unlocked; without it the code is the constant CODE_INIT.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int          SW_W         = 8,
    parameter int          CODE_LEN     = 4,
    parameter logic [CODE_LEN*$clog2(SW_W)-1:0] CODE_INIT = 12'o3210,
    parameter int          MAX_FAILS    = 3,
    parameter logic [31:0] UNLOCK_CYC   = DEF_UNLOCK_CYC,
    parameter logic [31:0] LOCKOUT_CYC  = DEF_LOCKOUT_CYC,
    parameter logic [31:0] ENTRY_TO_CYC = DEF_ENTRY_TO_CYC
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            key_vld,
    input  logic [$clog2(SW_W)-1:0]         key_idx,
    input  logic                            relock,
    input  logic                            prog_req,
    output logic                            locked,
    output logic                            alarm,
    output logic                            fail_pulse,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt,
    output logic [$clog2(MAX_FAILS+1)-1:0]  fail_cnt
);

    localparam int IDX_W  = $clog2(SW_W);
    localparam int CODE_W = CODE_LEN * IDX_W;
    localparam int DCNT_W = $clog2(CODE_LEN + 1);
    localparam int FCNT_W = $clog2(MAX_FAILS + 1);
    localparam logic [DCNT_W-1:0] LAST_DIGIT = DCNT_W'(CODE_LEN - 1);
    localparam logic [FCNT_W-1:0] FAIL_LIMIT = FCNT_W'(MAX_FAILS);

    lock_state_t       state;
    lock_state_t       state_nxt;
    logic [DCNT_W-1:0] digit_nxt;
    logic [FCNT_W-1:0] fail_nxt;
    logic [FCNT_W-1:0] fail_inc;
    logic              miss;
    logic              miss_nxt;
    logic              locked_nxt;
    logic              alarm_nxt;
    logic              fail_pulse_nxt;
    logic              key_accept;
    logic              timer_clear;
    logic              timer_expired;
    logic [31:0]       timer_limit;
    logic [CODE_W-1:0] code;
    logic [63:0]       code_ext;
    logic              key_in_range;
    logic              digit_hit;

    // With a non-power-of-two keypad some encodings name no real key and can
    // never match a code digit.
    generate
        if ((1 << IDX_W) == SW_W) begin : g_full_range
            assign key_in_range = 1'b1;
        end else begin : g_part_range
            assign key_in_range = ({{(32-IDX_W){1'b0}}, key_idx} < 32'(SW_W));
        end
    endgenerate

    assign code_ext  = 64'(code);
    assign digit_hit = key_in_range &&
                       (digit_slice(code_ext, 32'(digit_cnt), IDX_W) == 8'(key_idx));
    assign fail_inc  = fail_cnt + 1'b1;

`ifdef CODE_PROG_EN
    logic [CODE_W-1:0] shadow;
    logic [CODE_W-1:0] shadow_nxt;
    logic [CODE_W-1:0] code_nxt;

    // Live code and the shadow being filled during programming; the live code
    // only changes once a complete new code has been collected.
    always_ff @(posedge clk) begin
        if (rst) begin
            code   <= CODE_INIT;
            shadow <= '0;
        end else begin
            code   <= code_nxt;
            shadow <= shadow_nxt;
        end
    end
`else
    logic prog_req_unused;

    assign code            = CODE_INIT;
    assign prog_req_unused = prog_req;
`endif

    // Pick the timeout that applies to the current state.
    always_comb begin
        timer_limit = ENTRY_TO_CYC;
        case (state)
            UNLOCKED: timer_limit = UNLOCK_CYC;
            LOCKOUT:  timer_limit = LOCKOUT_CYC;
            default:  timer_limit = ENTRY_TO_CYC;
        endcase
    end

    // Every state change and every accepted key restarts the shared timer.
    assign timer_clear = (state_nxt != state) || key_accept;

    cycle_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    // Next-state logic: digit collection, verdict on the last digit, lockout
    // and unlock timing, and optional code programming.
    always_comb begin
        state_nxt      = state;
        digit_nxt      = digit_cnt;
        fail_nxt       = fail_cnt;
        miss_nxt       = miss;
        fail_pulse_nxt = 1'b0;
        key_accept     = 1'b0;
`ifdef CODE_PROG_EN
        shadow_nxt     = shadow;
        code_nxt       = code;
`endif
        case (state)
            ENTRY: begin
                if (key_vld) begin
                    key_accept = 1'b1;
                    if (digit_cnt == LAST_DIGIT) begin
                        digit_nxt = '0;
                        miss_nxt  = 1'b0;
                        if (miss || !digit_hit) begin
                            fail_pulse_nxt = 1'b1;
                            fail_nxt       = fail_inc;
                            if (fail_inc == FAIL_LIMIT) begin
                                state_nxt = LOCKOUT;
                            end
                        end else begin
                            fail_nxt  = '0;
                            state_nxt = UNLOCKED;
                        end
                    end else begin
                        digit_nxt = digit_cnt + 1'b1;
                        miss_nxt  = miss || !digit_hit;
                    end
                end else if ((digit_cnt != '0) && timer_expired) begin
                    digit_nxt = '0;
                    miss_nxt  = 1'b0;
                end
            end
            UNLOCKED: begin
                if (relock || timer_expired) begin
                    state_nxt = ENTRY;
                end
`ifdef CODE_PROG_EN
                else if (prog_req) begin
                    state_nxt = PROG;
                    digit_nxt = '0;
                end
`endif
            end
            LOCKOUT: begin
                if (timer_expired) begin
                    state_nxt = ENTRY;
                    fail_nxt  = '0;
                end
            end
`ifdef CODE_PROG_EN
            PROG: begin
                if (relock) begin
                    state_nxt = ENTRY;
                    digit_nxt = '0;
                end else if (key_vld) begin
                    key_accept = 1'b1;
                    shadow_nxt[32'(digit_cnt)*IDX_W +: IDX_W] = key_idx;
                    if (digit_cnt == LAST_DIGIT) begin
                        code_nxt  = shadow_nxt;
                        digit_nxt = '0;
                        state_nxt = UNLOCKED;
                    end else begin
                        digit_nxt = digit_cnt + 1'b1;
                    end
                end else if (timer_expired) begin
                    state_nxt = ENTRY;
                    digit_nxt = '0;
                end
            end
`endif
            default: begin
                state_nxt = ENTRY;
                digit_nxt = '0;
                miss_nxt  = 1'b0;
            end
        endcase
        locked_nxt = !((state_nxt == UNLOCKED) || (state_nxt == PROG));
        alarm_nxt  = (state_nxt == LOCKOUT);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ENTRY;
            digit_cnt  <= '0;
            fail_cnt   <= '0;
            miss       <= 1'b0;
            locked     <= 1'b1;
            alarm      <= 1'b0;
            fail_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            digit_cnt  <= digit_nxt;
            fail_cnt   <= fail_nxt;
            miss       <= miss_nxt;
            locked     <= locked_nxt;
            alarm      <= alarm_nxt;
            fail_pulse <= fail_pulse_nxt;
        end
    end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl with shortened timeouts; expected outputs
// are queued as each step is driven and compared after the clock edge.
module tb_code_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_vld;
    logic [2:0] key_idx;
    logic       relock;
    logic       prog_req;
    logic       locked;
    logic       alarm;
    logic       fail_pulse;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    typedef struct {
        string      tag;
        logic       locked;
        logic       alarm;
        logic       fail_pulse;
        logic [2:0] digit_cnt;
        logic [1:0] fail_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    code_lock_ctrl #(
        .UNLOCK_CYC   (32'd20),
        .LOCKOUT_CYC  (32'd30),
        .ENTRY_TO_CYC (32'd10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_vld    (key_vld),
        .key_idx    (key_idx),
        .relock     (relock),
        .prog_req   (prog_req),
        .locked     (locked),
        .alarm      (alarm),
        .fail_pulse (fail_pulse),
        .digit_cnt  (digit_cnt),
        .fail_cnt   (fail_cnt)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    task automatic checkField(input string tag, input string field,
                              input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic expectOut(input string tag, input logic l, input logic a,
                             input logic fp, input logic [2:0] dc, input logic [1:0] fc);
        exp_t e;
        e.tag        = tag;
        e.locked     = l;
        e.alarm      = a;
        e.fail_pulse = fp;
        e.digit_cnt  = dc;
        e.fail_cnt   = fc;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic kv, input logic [2:0] ki,
                                 input logic rl, input logic pr);
        key_vld  = kv;
        key_idx  = ki;
        relock   = rl;
        prog_req = pr;
        @(posedge clk);
        #1;
        key_vld  = 1'b0;
        key_idx  = 3'd0;
        relock   = 1'b0;
        prog_req = 1'b0;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            checkField(e.tag, "locked",     8'(locked),     8'(e.locked));
            checkField(e.tag, "alarm",      8'(alarm),      8'(e.alarm));
            checkField(e.tag, "fail_pulse", 8'(fail_pulse), 8'(e.fail_pulse));
            checkField(e.tag, "digit_cnt",  8'(digit_cnt),  8'(e.digit_cnt));
            checkField(e.tag, "fail_cnt",   8'(fail_cnt),   8'(e.fail_cnt));
        end
    endtask

    task automatic step(input string tag, input logic kv, input logic [2:0] ki,
                        input logic rl, input logic pr,
                        input logic l, input logic a, input logic fp,
                        input logic [2:0] dc, input logic [1:0] fc);
        expectOut(tag, l, a, fp, dc, fc);
        applyStimulus(kv, ki, rl, pr);
        checkOutput();
    endtask

    task automatic unlockSeq(input string tag, input logic [2:0] d0, input logic [2:0] d1,
                             input logic [2:0] d2, input logic [2:0] d3,
                             input logic [1:0] fc_in);
        step({tag, "_d0"}, 1'b1, d0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, fc_in);
        step({tag, "_d1"}, 1'b1, d1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, fc_in);
        step({tag, "_d2"}, 1'b1, d2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, fc_in);
        step({tag, "_d3"}, 1'b1, d3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    endtask

    task automatic wrongSeq(input string tag, input logic [2:0] d0, input logic [2:0] d1,
                            input logic [2:0] d2, input logic [2:0] d3,
                            input logic [1:0] fc_in, input logic [1:0] fc_out,
                            input logic alarm_out);
        step({tag, "_d0"}, 1'b1, d0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, fc_in);
        step({tag, "_d1"}, 1'b1, d1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, fc_in);
        step({tag, "_d2"}, 1'b1, d2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, fc_in);
        step({tag, "_d3"}, 1'b1, d3, 1'b0, 1'b0, 1'b1, alarm_out, 1'b1, 3'd0, fc_out);
    endtask

    // Directed scenario sequence.
    initial begin
        rst      = 1'b1;
        key_vld  = 1'b0;
        key_idx  = 3'd0;
        relock   = 1'b0;
        prog_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expectOut("reset", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        checkOutput();
        rst = 1'b0;

        $display("[TB] correct code and auto-relock");
        unlockSeq("t1", 3'd0, 3'd1, 3'd2, 3'd3, 2'd0);
        for (int i = 1; i <= 19; i++) begin
            step($sformatf("t1_hold%0d", i), (i == 5), 3'd2, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        end
        step("t1_expire", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);

        $display("[TB] single wrong code");
        wrongSeq("t2", 3'd0, 3'd5, 3'd2, 3'd3, 2'd0, 2'd1, 1'b0);
        step("t2_after", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1);

        $display("[TB] lockout");
        wrongSeq("t3a", 3'd1, 3'd1, 3'd1, 3'd1, 2'd1, 2'd2, 1'b0);
        step("t3a_after", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd2);
        wrongSeq("t3b", 3'd7, 3'd6, 3'd5, 3'd4, 2'd2, 2'd3, 1'b1);
        for (int i = 1; i <= 29; i++) begin
            step($sformatf("t3_lock%0d", i), (i <= 4), 3'(i - 1), (i == 5), 1'b0,
                 1'b1, 1'b1, 1'b0, 3'd0, 2'd3);
        end
        step("t3_release", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        unlockSeq("t3_open", 3'd0, 3'd1, 3'd2, 3'd3, 2'd0);
        step("t3_relock", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);

        $display("[TB] entry timeout");
        step("t4_k0", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 2'd0);
        step("t4_k1", 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 2'd0);
        for (int i = 1; i <= 9; i++) begin
            step($sformatf("t4_idle%0d", i), 1'b0, 3'd0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 3'd2, 2'd0);
        end
        step("t4_timeout", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        unlockSeq("t4_open", 3'd0, 3'd1, 3'd2, 3'd3, 2'd0);
        step("t4_relock", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        step("t4_e0", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 2'd0);
        for (int i = 1; i <= 9; i++) begin
            step($sformatf("t4_wait%0d", i), 1'b0, 3'd0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 3'd1, 2'd0);
        end
        step("t4_e1_on_expiry", 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 2'd0);
        for (int i = 1; i <= 9; i++) begin
            step($sformatf("t4_rewait%0d", i), 1'b0, 3'd0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 3'd2, 2'd0);
        end
        step("t4_e2_on_expiry", 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 2'd0);
        step("t4_e3", 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        step("t4_relock2", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);

        $display("[TB] relock and reset mid-entry");
        unlockSeq("t5", 3'd0, 3'd1, 3'd2, 3'd3, 2'd0);
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("t5_wait%0d", i), 1'b0, 3'd0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        end
        step("t5_relock", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        wrongSeq("t5w", 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 2'd1, 1'b0);
        step("t5_pk0", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 2'd1);
        step("t5_pk4", 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 2'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        expectOut("t5_reset", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        checkOutput();
        rst = 1'b0;
        unlockSeq("t5_open", 3'd0, 3'd1, 3'd2, 3'd3, 2'd0);
        step("t5_relock2", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);

`ifdef CODE_PROG_EN
        $display("[TB] code programming");
        unlockSeq("t6u", 3'd0, 3'd1, 3'd2, 3'd3, 2'd0);
        step("t6_prog", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        step("t6_p7", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0);
        step("t6_p6", 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0);
        step("t6_p5", 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd0);
        step("t6_p4", 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        step("t6_still_open", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        step("t6_relock", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        wrongSeq("t6_old", 3'd0, 3'd1, 3'd2, 3'd3, 2'd0, 2'd1, 1'b0);
        step("t6_old_after", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1);
        unlockSeq("t6_new", 3'd7, 3'd6, 3'd5, 3'd4, 2'd1);
        step("t6_prog2", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        step("t6_a1", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0);
        step("t6_a2", 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0);
        for (int i = 1; i <= 9; i++) begin
            step($sformatf("t6_idle%0d", i), 1'b0, 3'd0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 3'd2, 2'd0);
        end
        step("t6_abandon", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        unlockSeq("t6_keep", 3'd7, 3'd6, 3'd5, 3'd4, 2'd0);
        step("t6_prog3", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        step("t6_b0", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0);
        step("t6_prog_relock", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
        unlockSeq("t6_keep2", 3'd7, 3'd6, 3'd5, 3'd4, 2'd0);
        step("t6_end", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
`else
        $display("[TB] programming request ignored");
        unlockSeq("t6u", 3'd0, 3'd1, 3'd2, 3'd3, 2'd0);
        step("t6_prog_ign", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        step("t6_key_ign", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        step("t6_end", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
